trng_vn: RTL and testbench

Parametrised true-random-number generator core that turns a raw entropy bit stream, the temperature-sensor LSB sampled once per conversion, into debiased random words. It adds von Neumann debiasing, a repetition-count health test with a sticky fault flag, and a ready/valid output handshake with backpressure. The block sits between the temperature-sensor I2C reader, which supplies `RAW_BIT`/`RAW_VALID`, and any consumer of random words.

---
 rtl/trng_vn_if.sv | 33 +++
 rtl/trng_vn.sv | 150 +++++++++++++++
 tb/tb_trng_vn.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_vn_if.sv
// Raw-sample input, word handshake and fault flag of the TRNG core.
// master is the core side, slave is the sensor/consumer side.
interface trng_vn_if #(
    parameter int WIDTH = 512
);
    logic             EN;
    logic             RAW_BIT;
    logic             RAW_VALID;
    logic             READY;
    logic [WIDTH-1:0] RANDOM_NUMBER;
    logic             VALID;
    logic             FAULT;

    modport master (
        input  EN,
        input  RAW_BIT,
        input  RAW_VALID,
        input  READY,
        output RANDOM_NUMBER,
        output VALID,
        output FAULT
    );

    modport slave (
        output EN,
        output RAW_BIT,
        output RAW_VALID,
        output READY,
        input  RANDOM_NUMBER,
        input  VALID,
        input  FAULT
    );
endinterface

// File: rtl/trng_vn.sv
// Von Neumann debiased TRNG core with repetition-count health test
// and a one-deep ready/valid output slot.
module trng_vn #(
    parameter int WIDTH     = 512,
    parameter int REP_LIMIT = 32
) (
    input logic       SCLK,
    input logic       RST,
    trng_vn_if.master bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

    typedef enum logic [1:0] {
        COLLECT,
        FULL,
        FAULTED
    } state_t;

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic             first_q, first_d;
    logic             prev_q, prev_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;

    logic             sample;
    logic             xfer;
    logic             emit;
    logic             trip;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            state_q <= COLLECT;
            phase_q <= 1'b0;
            first_q <= 1'b0;
            prev_q  <= 1'b0;
            rep_q   <= '0;
            cnt_q   <= '0;
            sreg_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            first_q <= first_d;
            prev_q  <= prev_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        first_d = first_q;
        prev_d  = prev_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        out_d   = out_q;
        valid_d = valid_q;
        fault_d = fault_q;

        sample  = bus.EN & bus.RAW_VALID & (state_q != FAULTED);
        xfer    = valid_q & bus.READY;
        // A pair emits its first bit when the two samples differ.
        emit    = sample & phase_q & (first_q != bus.RAW_BIT);
        shifted = {sreg_q[WIDTH-2:0], first_q};
        trip    = 1'b0;

        if (xfer)
            valid_d = 1'b0;

        if (sample) begin
            phase_d = ~phase_q;
            prev_d  = bus.RAW_BIT;
            if (!phase_q)
                first_d = bus.RAW_BIT;
            if (rep_q == '0 || bus.RAW_BIT != prev_q)
                rep_d = RW'(1);
            else if (rep_q != REP_MAX)
                rep_d = rep_q + 1'b1;
            trip = (rep_d == REP_MAX);
        end

        if (!bus.EN)
            phase_d = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (emit) begin
                    sreg_d = shifted;
                    if (cnt_q != LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (!valid_q || bus.READY) begin
                        out_d   = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (xfer) begin
                    out_d   = sreg_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            FAULTED: begin
            end
            default: state_d = COLLECT;
        endcase

        // Health-test failure overrides any word completing on this edge.
        if (trip) begin
            state_d = FAULTED;
            fault_d = 1'b1;
            valid_d = 1'b0;
            rep_d   = '0;
            phase_d = 1'b0;
            first_d = 1'b0;
            cnt_d   = '0;
            sreg_d  = '0;
            out_d   = '0;
        end
    end

    assign bus.RANDOM_NUMBER = valid_q ? out_q : '0;
    assign bus.VALID         = valid_q;
    assign bus.FAULT         = fault_q;

endmodule

// File: tb/tb_trng_vn.sv
// Directed bench for trng_vn with WIDTH=8, REP_LIMIT=4.
// Observed tuple is {VALID, FAULT, RANDOM_NUMBER}.
module tb_trng_vn;

    localparam int W  = 8;
    localparam int RL = 4;

    logic SCLK = 1'b0;
    logic RST  = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [W+1:0] obs;

    trng_vn_if #(.WIDTH(W)) bus();

    trng_vn #(
        .WIDTH(W),
        .REP_LIMIT(RL)
    ) dut (
        .SCLK(SCLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 SCLK = ~SCLK;

    // Called at a negedge; strobes one sample across the next posedge.
    task automatic smp(input logic b);
        bus.EN        = 1'b1;
        bus.RAW_BIT   = b;
        bus.RAW_VALID = 1'b1;
        @(negedge SCLK);
        bus.RAW_VALID = 1'b0;
    endtask

    task automatic pairs(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            smp(a);
            smp(b);
        end
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(negedge SCLK);
        RST = 1'b0;
    endtask

    task automatic test_reset_state();
        bus.EN        = 1'b0;
        bus.RAW_BIT   = 1'b0;
        bus.RAW_VALID = 1'b0;
        bus.READY     = 1'b0;
        RST           = 1'b1;
        @(negedge SCLK);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", obs, 10'h000);
        end
        RST = 1'b0;
        @(negedge SCLK);
    endtask

    task automatic test_debias();
        bus.READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pairs(1'b1, 1'b0, 1);
            pairs(1'b0, 1'b1, 1);
        end
        pairs(1'b1, 1'b0, 1);
        smp(1'b0);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL debias_15 got=%h exp=%h", obs, 10'h000);
        end
        smp(1'b1);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h2AA) begin
            bad++;
            $display("FAIL debias_word got=%h exp=%h", obs, 10'h2AA);
        end
        @(negedge SCLK);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL debias_drop got=%h exp=%h", obs, 10'h000);
        end
    endtask

    task automatic test_discards();
        bus.READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pairs(1'b0, 1'b0, 1);
            pairs(1'b1, 1'b0, 1);
            pairs(1'b1, 1'b1, 1);
            if (i < 3)
                pairs(1'b0, 1'b1, 1);
        end
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL discard_early got=%h exp=%h", obs, 10'h000);
        end
        pairs(1'b0, 1'b1, 1);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h2AA) begin
            bad++;
            $display("FAIL discard_word got=%h exp=%h", obs, 10'h2AA);
        end
        @(negedge SCLK);
        // Half pair, then EN low with a stray strobe.
        for (int i = 0; i < 2; i++) begin
            pairs(1'b1, 1'b0, 1);
            pairs(1'b0, 1'b1, 1);
        end
        smp(1'b0);
        bus.EN        = 1'b0;
        bus.RAW_BIT   = 1'b1;
        bus.RAW_VALID = 1'b1;
        @(negedge SCLK);
        bus.RAW_VALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pairs(1'b1, 1'b0, 1);
            pairs(1'b0, 1'b1, 1);
        end
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h2AA) begin
            bad++;
            $display("FAIL en_drop_word got=%h exp=%h", obs, 10'h2AA);
        end
        @(negedge SCLK);
    endtask

    task automatic test_back_to_back();
        bus.READY = 1'b0;
        pairs(1'b1, 1'b0, 8);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h2FF) begin
            bad++;
            $display("FAIL bp_first got=%h exp=%h", obs, 10'h2FF);
        end
        pairs(1'b0, 1'b1, 8);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h2FF) begin
            bad++;
            $display("FAIL bp_hold got=%h exp=%h", obs, 10'h2FF);
        end
        pairs(1'b1, 1'b0, 2);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h2FF) begin
            bad++;
            $display("FAIL bp_full got=%h exp=%h", obs, 10'h2FF);
        end
        bus.READY = 1'b1;
        @(negedge SCLK);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h200) begin
            bad++;
            $display("FAIL bp_second got=%h exp=%h", obs, 10'h200);
        end
        @(negedge SCLK);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL bp_empty got=%h exp=%h", obs, 10'h000);
        end
        pairs(1'b1, 1'b0, 7);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL bp_restart7 got=%h exp=%h", obs, 10'h000);
        end
        pairs(1'b1, 1'b0, 1);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h2FF) begin
            bad++;
            $display("FAIL bp_restart8 got=%h exp=%h", obs, 10'h2FF);
        end
        @(negedge SCLK);
    endtask

    task automatic test_fault();
        bus.READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pairs(1'b0, 1'b1, 1);
            pairs(1'b1, 1'b0, 1);
        end
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h255) begin
            bad++;
            $display("FAIL fault_pending got=%h exp=%h", obs, 10'h255);
        end
        smp(1'b1);
        smp(1'b1);
        smp(1'b1);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h255) begin
            bad++;
            $display("FAIL fault_rep3 got=%h exp=%h", obs, 10'h255);
        end
        smp(1'b1);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h100) begin
            bad++;
            $display("FAIL fault_trip got=%h exp=%h", obs, 10'h100);
        end
        bus.READY = 1'b1;
        pairs(1'b1, 1'b0, 20);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h100) begin
            bad++;
            $display("FAIL fault_sticky got=%h exp=%h", obs, 10'h100);
        end
    endtask

    task automatic test_reset();
        pulse_reset();
        bus.READY = 1'b0;
        pairs(1'b1, 1'b0, 8);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h2FF) begin
            bad++;
            $display("FAIL rst_prep got=%h exp=%h", obs, 10'h2FF);
        end
        pairs(1'b1, 1'b0, 2);
        #2 RST = 1'b1;
        #1;
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL rst_async got=%h exp=%h", obs, 10'h000);
        end
        @(negedge SCLK);
        RST = 1'b0;
        pairs(1'b1, 1'b0, 7);
        smp(1'b1);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL rst_15 got=%h exp=%h", obs, 10'h000);
        end
        smp(1'b0);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h2FF) begin
            bad++;
            $display("FAIL rst_16 got=%h exp=%h", obs, 10'h2FF);
        end
    endtask

    task automatic test_rep_reset();
        pulse_reset();
        bus.READY = 1'b1;
        smp(1'b1);
        smp(1'b1);
        smp(1'b1);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL rep_three got=%h exp=%h", obs, 10'h000);
        end
        smp(1'b0);
        smp(1'b0);
        smp(1'b0);
        smp(1'b1);
        obs = {bus.VALID, bus.FAULT, bus.RANDOM_NUMBER};
        total++;
        if (obs !== 10'h000) begin
            bad++;
            $display("FAIL rep_mixed got=%h exp=%h", obs, 10'h000);
        end
    endtask

    initial begin
        test_reset_state();
        test_debias();
        test_discards();
        test_back_to_back();
        test_fault();
        test_reset();
        test_rep_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
